alu_arbiter: RTL and testbench

//   Shares one combinational 16-bit ALU (6-bit op, zr/ng flags) between two

---
 rtl/alu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters using
// round-robin grant, registered ALU inputs and a single tagged response channel.
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zr,
  output logic              rsp_ng,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] alu_x_q, alu_x_d;
  logic [DATA_W-1:0] alu_y_q, alu_y_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zr_q, rsp_zr_d;
  logic              rsp_ng_q, rsp_ng_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant_sel;
  logic              in_idle;
  logic              handshake;
  logic              sel_supported;
  logic [DATA_W-1:0] sel_x;
  logic [DATA_W-1:0] sel_y;
  logic [OP_W-1:0]   sel_op;

  // Round-robin pick: a lone requester wins, contention goes to the one not served last
  always_comb begin
    if (req0_valid && req1_valid) grant_sel = ~last_grant_q;
    else                          grant_sel = req1_valid;
  end

  assign in_idle    = (state_q == IDLE);
  assign req0_ready = in_idle & req0_valid & ~grant_sel;
  assign req1_ready = in_idle & req1_valid & grant_sel;
  assign handshake  = req0_ready | req1_ready;
  assign sel_x      = grant_sel ? req1_x  : req0_x;
  assign sel_y      = grant_sel ? req1_y  : req0_y;
  assign sel_op     = grant_sel ? req1_op : req0_op;

  // Opcode decode: only codes the ALU implements are forwarded to it
  always_comb begin
    sel_supported = 1'b0;
    case (sel_op)
      6'b010101, 6'b111111, 6'b010111, 6'b001100, 6'b000011, 6'b101100,
      6'b110001, 6'b111100, 6'b110011, 6'b111110, 6'b111011, 6'b011100,
      6'b010011, 6'b010000, 6'b110010, 6'b111000, 6'b000000:
        sel_supported = 1'b1;
      default:
        sel_supported = 1'b0;
    endcase
  end

  // Next state for IDLE -> EXEC -> RESP -> IDLE; rejected ops jump straight to RESP
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_zr_d     = rsp_zr_q;
    rsp_ng_d     = rsp_ng_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          rsp_id_d     = grant_sel;
          last_grant_d = grant_sel;
          if (sel_supported) begin
            alu_x_d  = sel_x;
            alu_y_d  = sel_y;
            alu_op_d = sel_op;
            state_d  = EXEC;
          end else begin
            rsp_data_d  = '0;
            rsp_zr_d    = 1'b0;
            rsp_ng_d    = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_zr_d    = alu_zr;
        rsp_ng_d    = alu_ng;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any op in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zr_q     <= 1'b0;
      rsp_ng_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zr_q     <= rsp_zr_d;
      rsp_ng_q     <= rsp_ng_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zr    = rsp_zr_q;
  assign rsp_ng    = rsp_ng_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of grant order, op decode, response
// back-pressure and asynchronous reset for alu_arbiter.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_x, req0_y;
  logic [5:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_x, req1_y;
  logic [5:0]  req1_op;
  logic [15:0] alu_x, alu_y;
  logic [5:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_zr, rsp_ng, rsp_err;
  logic        busy;

  int checks;
  int failures;

  alu_arbiter #(.DATA_W(16), .OP_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng),
    .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU with the handful of opcodes the scenarios use
  always_comb begin
    case (alu_op)
      6'b010000: alu_out = alu_x + alu_y;
      6'b110010: alu_out = alu_x - alu_y;
      6'b111000: alu_out = alu_y - alu_x;
      6'b011100: alu_out = alu_x - 16'd1;
      default:   alu_out = alu_x & alu_y;
    endcase
  end
  assign alu_zr = (alu_out == 16'd0);
  assign alu_ng = alu_out[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err} !== 22'd0) begin
      failures++;
      $display("[TB] FAIL reset_rsp got=%h exp=0", {busy, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err});
    end
    checks++;
    if ({alu_x, alu_y, alu_op, req0_ready, req1_ready} !== 40'd0) begin
      failures++;
      $display("[TB] FAIL reset_alu got=%h exp=0", {alu_x, alu_y, alu_op, req0_ready, req1_ready});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    req0_valid = 1'b1; req0_x = 16'd5; req0_y = 16'd3; req0_op = 6'b010000;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL single_ready got=%b exp=10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({busy, rsp_valid, alu_x, alu_y, alu_op} !== {1'b1, 1'b0, 16'd5, 16'd3, 6'b010000}) begin
      failures++;
      $display("[TB] FAIL single_exec got=%h", {busy, rsp_valid, alu_x, alu_y, alu_op});
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err} !== {1'b1, 1'b0, 16'd8, 3'b000}) begin
      failures++;
      $display("[TB] FAIL single_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err}, {1'b1, 1'b0, 16'd8, 3'b000});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL single_done got=%b exp=00", {busy, rsp_valid});
    end
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req0_valid = 1'b1; req0_x = 16'd5; req0_y = 16'd5; req0_op = 6'b110010;
    req1_valid = 1'b1; req1_x = 16'd2; req1_y = 16'd7; req1_op = 6'b111000;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL contend_first got=%b exp=10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err} !== {1'b1, 1'b0, 16'd0, 3'b100}) begin
      failures++;
      $display("[TB] FAIL contend_rsp0 got=%h exp=%h", {rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err}, {1'b1, 1'b0, 16'd0, 3'b100});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL contend_second got=%b exp=01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err} !== {1'b1, 1'b1, 16'd5, 3'b000}) begin
      failures++;
      $display("[TB] FAIL contend_rsp1 got=%h exp=%h", {rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err}, {1'b1, 1'b1, 16'd5, 3'b000});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_alternate();
    logic        exp_id;
    logic [15:0] exp_data;
    req1_valid = 1'b1; req1_x = 16'd10; req1_y = 16'd0; req1_op = 6'b011100;
    req0_x = 16'd1; req0_y = 16'd1; req0_op = 6'b010000;
    for (int i = 0; i < 4; i++) begin
      exp_id   = (i % 2 == 1);
      exp_data = exp_id ? 16'd9 : 16'd2;
      req0_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
        failures++;
        $display("[TB] FAIL alt_grant%0d got=%b exp=%b", i, {req0_ready, req1_ready}, {~exp_id, exp_id});
      end
      tick();
      req0_valid = 1'b0;
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, exp_id, exp_data}) begin
        failures++;
        $display("[TB] FAIL alt_rsp%0d got=%h exp=%h", i, {rsp_valid, rsp_id, rsp_data}, {1'b1, exp_id, exp_data});
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_unsupported();
    req0_valid = 1'b1; req0_x = 16'd9; req0_y = 16'd9; req0_op = 6'b101010;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL unsup_ready got=%b exp=10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({busy, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err} !== {1'b1, 1'b1, 1'b0, 16'd0, 3'b001}) begin
      failures++;
      $display("[TB] FAIL unsup_rsp got=%h exp=%h", {busy, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err}, {1'b1, 1'b1, 1'b0, 16'd0, 3'b001});
    end
    checks++;
    if ({alu_x, alu_y, alu_op} !== {16'd10, 16'd0, 6'b011100}) begin
      failures++;
      $display("[TB] FAIL unsup_alu_hold got=%h exp=%h", {alu_x, alu_y, alu_op}, {16'd10, 16'd0, 6'b011100});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL unsup_done got=%b exp=00", {busy, rsp_valid});
    end
  endtask

  task automatic test_op_decode();
    logic [5:0] ops [21];
    logic       sup [21];
    ops = '{6'b010101, 6'b111111, 6'b010111, 6'b001100, 6'b000011, 6'b101100,
            6'b110001, 6'b111100, 6'b110011, 6'b111110, 6'b111011, 6'b011100,
            6'b010011, 6'b010000, 6'b110010, 6'b111000, 6'b000000,
            6'b101010, 6'b111010, 6'b000001, 6'b111101};
    for (int i = 0; i < 21; i++) sup[i] = (i < 17);
    req0_x = 16'd3; req0_y = 16'd3;
    for (int i = 0; i < 21; i++) begin
      req0_op = ops[i];
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      checks++;
      if ({busy, rsp_valid} !== {1'b1, ~sup[i]}) begin
        failures++;
        $display("[TB] FAIL decode_path op=%b got=%b exp=%b", ops[i], {busy, rsp_valid}, {1'b1, ~sup[i]});
      end
      if (sup[i]) tick();
      checks++;
      if ({rsp_valid, rsp_err} !== {1'b1, ~sup[i]}) begin
        failures++;
        $display("[TB] FAIL decode_err op=%b got=%b exp=%b", ops[i], {rsp_valid, rsp_err}, {1'b1, ~sup[i]});
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_x = 16'd0; req0_y = 16'd0; req0_op = 6'b011100;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_x = 16'd4; req1_y = 16'd4; req1_op = 6'b010000;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err, req1_ready} !== {1'b1, 1'b0, 16'hFFFF, 3'b010, 1'b0}) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d got=%h exp=%h", i, {rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err, req1_ready}, {1'b1, 1'b0, 16'hFFFF, 3'b010, 1'b0});
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_exit_ready got=%b exp=0", req1_ready);
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL bp_release got=%b exp=01", {rsp_valid, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b1, 16'd8, 1'b0}) begin
      failures++;
      $display("[TB] FAIL bp_req1_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_data, rsp_err}, {1'b1, 1'b1, 16'd8, 1'b0});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    req0_valid = 1'b1; req0_x = 16'd5; req0_y = 16'd3; req0_op = 6'b010000;
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({busy, rsp_valid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL rst_exec_pre got=%b exp=10", {busy, rsp_valid});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err, alu_x, alu_y, alu_op, req0_ready, req1_ready} !== 62'd0) begin
      failures++;
      $display("[TB] FAIL rst_exec_async got=%h exp=0", {busy, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, rsp_err, alu_x, alu_y, alu_op, req0_ready, req1_ready});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL rst_exec_after%0d got=%b exp=00", i, {busy, rsp_valid});
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_op = '0;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_op = '0;
    test_reset();
    test_single_add();
    test_contention();
    test_alternate();
    test_unsupported();
    test_op_decode();
    test_backpressure();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
